ibex_mem_responder: RTL and testbench



---
 rtl/ibex_mem_resp_pkg.sv | 13 +
 rtl/ibex_mem_resp_pipe.sv | 42 ++++
 rtl/prim_secded_inv_39_32_dec.sv | 42 ++++
 rtl/prim_secded_inv_39_32_enc.sv | 24 ++
 rtl/ibex_mem_responder.sv | 120 ++++++++++++
 tb/tb_ibex_mem_responder.sv | 300 ++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/ibex_mem_resp_pkg.sv
// Shared types and constants for the Ibex memory responder.
// Integrity is the inverted Hsiao (39,32) code used on the Ibex bus.
package ibex_mem_resp_pkg;

    localparam int IntgW = 7;
    localparam logic [IntgW-1:0] IntgZero = 7'h2A;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } mem_resp_t;

endpackage

// File: rtl/ibex_mem_resp_pipe.sv
// Fixed-latency response pipeline with synchronous clear.
// Idle slots carry zeros so the outputs read as an empty response.
module ibex_mem_resp_pipe
    import ibex_mem_resp_pkg::*;
#(
    parameter int Latency = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic        err_i,
    input  logic [31:0] rdata_i,
    output logic        valid_o,
    output logic        err_o,
    output logic [31:0] rdata_o
);

    mem_resp_t          stage_q [Latency];
    logic [Latency-1:0] valid_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            for (int i = 0; i < Latency; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            valid_q[0]       <= valid_i;
            stage_q[0].err   <= valid_i & err_i;
            stage_q[0].rdata <= valid_i ? rdata_i : '0;
            for (int i = 1; i < Latency; i++) begin
                valid_q[i] <= valid_q[i-1];
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign valid_o = valid_q[Latency-1];
    assign err_o   = stage_q[Latency-1].err;
    assign rdata_o = stage_q[Latency-1].rdata;

endmodule

// File: rtl/prim_secded_inv_39_32_dec.sv
// Inverted Hsiao (39,32) SECDED decoder with single-bit correction.
// err_o[0] flags a correctable error, err_o[1] an uncorrectable one.
module prim_secded_inv_39_32_dec (
    input  logic [38:0] data_i,
    output logic [31:0] data_o,
    output logic [6:0]  syndrome_o,
    output logic [1:0]  err_o
);

    localparam logic [31:0] M [7] = '{
        32'h2606BD25, 32'hDEBA8050, 32'h413D89AA, 32'h31234ED1,
        32'hC2C1323B, 32'h2DCC624C, 32'h98505586
    };
    localparam logic [6:0] Inv = 7'h2A;

    logic [6:0] col;

    always_comb begin
        syndrome_o = '0;
        for (int j = 0; j < 7; j++) begin
            syndrome_o[j] = ^(data_i[31:0] & M[j]) ^ data_i[32+j] ^ Inv[j];
        end
    end

    // A syndrome equal to a data column points at the flipped bit.
    always_comb begin
        data_o = data_i[31:0];
        col    = '0;
        for (int i = 0; i < 32; i++) begin
            for (int j = 0; j < 7; j++) begin
                col[j] = M[j][i];
            end
            if (syndrome_o == col) begin
                data_o[i] = ~data_i[i];
            end
        end
    end

    assign err_o[0] = ^syndrome_o;
    assign err_o[1] = ~(^syndrome_o) & (|syndrome_o);

endmodule

// File: rtl/prim_secded_inv_39_32_enc.sv
// Inverted Hsiao (39,32) SECDED encoder.
// Check bits are XORed with 7'h2A so an all-zero word is not a valid codeword.
module prim_secded_inv_39_32_enc (
    input  logic [31:0] data_i,
    output logic [38:0] data_o
);

    localparam logic [31:0] M [7] = '{
        32'h2606BD25, 32'hDEBA8050, 32'h413D89AA, 32'h31234ED1,
        32'hC2C1323B, 32'h2DCC624C, 32'h98505586
    };

    logic [6:0] parity;

    always_comb begin
        parity = '0;
        for (int j = 0; j < 7; j++) begin
            parity[j] = ^(data_i & M[j]);
        end
    end

    assign data_o = {parity ^ 7'h2A, data_i};

endmodule

// File: rtl/ibex_mem_responder.sv
// Word-array memory behind an Ibex req/gnt/rvalid port with bus integrity.
// Responses return in grant order after a fixed latency.
module ibex_mem_responder
    import ibex_mem_resp_pkg::*;
#(
    parameter int          MemDepth       = 1024,
    parameter logic [31:0] BaseAddr       = 32'h0010_0000,
    parameter int          Latency        = 1,
    parameter int          MaxOutstanding = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_i,
    output logic             gnt_o,
    input  logic             we_i,
    input  logic [3:0]       be_i,
    input  logic [31:0]      addr_i,
    input  logic [31:0]      wdata_i,
    input  logic [IntgW-1:0] wdata_intg_i,
    input  logic             stall_i,
    output logic             rvalid_o,
    output logic [31:0]      rdata_o,
    output logic [IntgW-1:0] rdata_intg_o,
    output logic             err_o
);

    localparam int IdxW = $clog2(MemDepth);
    localparam int CntW = $clog2(MaxOutstanding + 1);
    localparam logic [31:0]     Span   = 32'(4 * MemDepth);
    localparam logic [CntW-1:0] MaxOut = CntW'(MaxOutstanding);
    localparam logic [CntW-1:0] One    = CntW'(1);

    logic [31:0]     mem [MemDepth];
    logic [CntW-1:0] outstanding;
    logic [CntW-1:0] in_flight;
    logic [31:0]     offset;
    logic            in_range;
    logic [IdxW-1:0] idx;
    logic [6:0]      syndrome;
    logic [1:0]      dec_err;
    logic [31:0]     dec_data;
    logic            wr_ok;
    mem_resp_t       resp_d;
    logic [38:0]     enc;

    assign offset   = addr_i - BaseAddr;
    assign in_range = offset < Span;
    assign idx      = offset[2 +: IdxW];

    prim_secded_inv_39_32_dec u_dec (
        .data_i     ({wdata_intg_i, wdata_i}),
        .data_o     (dec_data),
        .syndrome_o (syndrome),
        .err_o      (dec_err)
    );

    logic unused_dec;
    assign unused_dec = ^{dec_data, dec_err};

    assign wr_ok = we_i & in_range & (syndrome == '0);

    // A slot retiring this cycle is free for a new grant.
    assign in_flight = outstanding - (rvalid_o ? One : '0);
    assign gnt_o     = req_i & ~stall_i & ~rst_i & (in_flight < MaxOut);

    always_ff @(posedge clk_i) begin
        if (gnt_o && wr_ok) begin
            for (int k = 0; k < 4; k++) begin
                if (be_i[k]) begin
                    mem[idx][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    always_comb begin
        resp_d = '0;
        if (we_i) begin
            resp_d.err = ~wr_ok;
        end else if (in_range) begin
            resp_d.rdata = mem[idx];
        end else begin
            resp_d.err = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outstanding <= '0;
        end else if (gnt_o && !rvalid_o) begin
            outstanding <= outstanding + One;
        end else if (!gnt_o && rvalid_o) begin
            outstanding <= outstanding - One;
        end
    end

    ibex_mem_resp_pipe #(
        .Latency (Latency)
    ) u_pipe (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (gnt_o),
        .err_i   (resp_d.err),
        .rdata_i (resp_d.rdata),
        .valid_o (rvalid_o),
        .err_o   (err_o),
        .rdata_o (rdata_o)
    );

    prim_secded_inv_39_32_enc u_enc (
        .data_i (rdata_o),
        .data_o (enc)
    );

    logic unused_enc;
    assign unused_enc = ^enc[31:0];

    assign rdata_intg_o = enc[38:32];

endmodule

// File: tb/tb_ibex_mem_responder.sv
// Bench for ibex_mem_responder: Latency=1 and Latency=3 instances
// checked every cycle against a queue-based reference model.
module tb_ibex_mem_responder;

    localparam int          MD   = 64;
    localparam logic [31:0] BASE = 32'h0010_0000;
    localparam int          MAXO = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req [2];
    logic        we [2];
    logic        stall [2];
    logic [3:0]  be [2];
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [6:0]  wintg [2];
    logic        gnt [2];
    logic        rvalid [2];
    logic        err [2];
    logic [31:0] rdata [2];
    logic [6:0]  rintg [2];

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ibex_mem_responder #(
        .MemDepth(MD), .BaseAddr(BASE), .Latency(1), .MaxOutstanding(MAXO)
    ) dut_a (
        .clk_i(clk), .rst_i(rst), .req_i(req[0]), .gnt_o(gnt[0]),
        .we_i(we[0]), .be_i(be[0]), .addr_i(addr[0]), .wdata_i(wdata[0]),
        .wdata_intg_i(wintg[0]), .stall_i(stall[0]), .rvalid_o(rvalid[0]),
        .rdata_o(rdata[0]), .rdata_intg_o(rintg[0]), .err_o(err[0])
    );

    ibex_mem_responder #(
        .MemDepth(MD), .BaseAddr(BASE), .Latency(3), .MaxOutstanding(MAXO)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .req_i(req[1]), .gnt_o(gnt[1]),
        .we_i(we[1]), .be_i(be[1]), .addr_i(addr[1]), .wdata_i(wdata[1]),
        .wdata_intg_i(wintg[1]), .stall_i(stall[1]), .rvalid_o(rvalid[1]),
        .rdata_o(rdata[1]), .rdata_intg_o(rintg[1]), .err_o(err[1])
    );

    function automatic int lat(int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic logic [6:0] enc(logic [31:0] d);
        logic [31:0] m [7];
        logic [6:0]  p;
        m = '{32'h2606BD25, 32'hDEBA8050, 32'h413D89AA, 32'h31234ED1,
              32'hC2C1323B, 32'h2DCC624C, 32'h98505586};
        for (int j = 0; j < 7; j++) p[j] = ^(d & m[j]);
        return p ^ 7'h2A;
    endfunction

    function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
        end
    endfunction

    // Reference model: per-instance memory image and a FIFO of due responses.
    typedef struct {
        int          due;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic [31:0] mm [2][MD];
    exp_t        eb [2][16];
    int          hd [2];
    int          tl [2];
    int          resp_n [2];

    task automatic mon(int k);
        exp_t        e;
        logic [31:0] off;
        int          idx;
        bit          due, xg, ok;
        due = (hd[k] != tl[k]) && (eb[k][hd[k] % 16].due == cyc);
        chk($sformatf("rvalid%0d", k), rvalid[k], due);
        if (due && rvalid[k]) begin
            e = eb[k][hd[k] % 16];
            chk($sformatf("rdata%0d", k), rdata[k], e.rdata);
            chk($sformatf("err%0d", k), err[k], e.err);
            chk($sformatf("intg%0d", k), rintg[k], enc(e.rdata));
            resp_n[k]++;
        end
        if (due) hd[k]++;
        xg = !rst && req[k] && !stall[k] && ((tl[k] - hd[k]) < MAXO);
        chk($sformatf("gnt%0d", k), gnt[k], xg);
        if (rst) begin
            hd[k] = tl[k];
        end else if (gnt[k]) begin
            off = addr[k] - BASE;
            idx = int'(off >> 2) % MD;
            e.due = cyc + lat(k);
            e.rdata = '0;
            if (we[k]) begin
                ok = (off < 4 * MD) && (wintg[k] == enc(wdata[k]));
                e.err = !ok;
                if (ok) begin
                    for (int b = 0; b < 4; b++)
                        if (be[k][b]) mm[k][idx][8*b +: 8] = wdata[k][8*b +: 8];
                end
            end else begin
                e.err = !(off < 4 * MD);
                if (off < 4 * MD) e.rdata = mm[k][idx];
            end
            eb[k][tl[k] % 16] = e;
            tl[k]++;
        end
    endtask

    always @(negedge clk) begin
        if (cyc > 0) begin
            for (int k = 0; k < 2; k++) mon(k);
        end
    end

    task automatic issue(input int k, input bit w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] b,
                         input logic [6:0] ig);
        bit ok;
        req[k] = 1'b1; we[k] = w; addr[k] = a;
        wdata[k] = d; be[k] = b; wintg[k] = ig;
        ok = 1'b0;
        for (int t = 0; t < 64 && !ok; t++) begin
            @(negedge clk);
            ok = gnt[k];
            @(posedge clk); #1;
        end
        if (!ok) chk("issue_timeout", 0, 1);
    endtask

    typedef struct {
        bit          w;
        logic [31:0] off;
        logic [31:0] d;
        logic [3:0]  b;
        bit          bad;
        bit          xerr;
        logic [31:0] xdata;
    } vec_t;

    vec_t vt [10];
    bit   pat [8];
    bit   glog [$];

    initial begin
        bit got;
        int n, base_n;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            req[k] = 0; we[k] = 0; stall[k] = 0; be[k] = 0;
            addr[k] = BASE; wdata[k] = 0; wintg[k] = 7'h2A;
        end

        @(posedge clk); @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_rvalid", rvalid[k], 0);
            chk("rst_err", err[k], 0);
            chk("rst_rdata", rdata[k], 0);
            chk("rst_intg", rintg[k], 7'h2A);
        end
        chk("rst_cnt_a", 32'(dut_a.outstanding), 0);
        chk("rst_cnt_b", 32'(dut_b.outstanding), 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        vt[0] = '{1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 32'h0};
        vt[1] = '{0, 32'h10, 32'h0, 4'h0, 0, 0, 32'hDEADBEEF};
        vt[2] = '{1, 32'h20, 32'h11223344, 4'hF, 0, 0, 32'h0};
        vt[3] = '{1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, 0, 32'h0};
        vt[4] = '{0, 32'h20, 32'h0, 4'h0, 0, 0, 32'h11BB33DD};
        vt[5] = '{0, 32'(4 * MD), 32'h0, 4'h0, 0, 1, 32'h0};
        vt[6] = '{1, 32'h10, 32'h00000055, 4'hF, 1, 1, 32'h0};
        vt[7] = '{0, 32'h10, 32'h0, 4'h0, 0, 0, 32'hDEADBEEF};
        vt[8] = '{1, 32'hFFFF_FFFC, 32'h12345678, 4'hF, 0, 1, 32'h0};
        vt[9] = '{1, 32'(4 * MD - 4), 32'h0BADF00D, 4'hF, 0, 0, 32'h0};

        for (int i = 0; i < 10; i++) begin
            issue(0, vt[i].w, BASE + vt[i].off, vt[i].d, vt[i].b,
                  enc(vt[i].d) ^ (vt[i].bad ? 7'h01 : 7'h00));
            req[0] = 1'b0;
            got = 1'b0;
            for (int t = 0; t < 8 && !got; t++) begin
                @(negedge clk);
                if (rvalid[0]) begin
                    got = 1'b1;
                    chk($sformatf("tbl%0d_lat", i), t, 0);
                    chk($sformatf("tbl%0d_err", i), err[0], vt[i].xerr);
                    chk($sformatf("tbl%0d_rdata", i), rdata[0], vt[i].xdata);
                    chk($sformatf("tbl%0d_intg", i), rintg[0], enc(vt[i].xdata));
                end
                @(posedge clk); #1;
            end
            if (!got) chk($sformatf("tbl%0d_timeout", i), 0, 1);
        end
        issue(0, 0, BASE + 32'(4 * MD - 4), 0, 0, 7'h2A);
        req[0] = 1'b0;
        @(negedge clk);
        chk("last_word", rdata[0], 32'h0BADF00D);
        @(posedge clk); #1;

        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) begin
                logic [31:0] d;
                d = 32'hC0DE_0000 + 32'(i * 257 + k);
                issue(k, 1, BASE + 32'(4 * i), d, 4'hF, enc(d));
            end
            req[k] = 1'b0;
        end
        repeat (6) @(posedge clk);
        #1;

        pat = '{1, 1, 0, 1, 1, 0, 1, 1};
        base_n = resp_n[1];
        n = 0;
        req[1] = 1'b1; we[1] = 1'b0;
        for (int t = 0; t < 20 && n < 6; t++) begin
            bit g;
            addr[1] = BASE + 32'(4 * n);
            @(negedge clk);
            g = gnt[1];
            glog.push_back(g);
            @(posedge clk); #1;
            if (g) n++;
        end
        req[1] = 1'b0;
        chk("bp_grants", n, 6);
        for (int i = 0; i < 8; i++) begin
            if (i < glog.size()) chk($sformatf("bp_gnt%0d", i), glog[i], pat[i]);
            else chk($sformatf("bp_gnt%0d_missing", i), 0, 1);
        end
        repeat (6) @(posedge clk);
        #1;
        chk("bp_responses", resp_n[1] - base_n, 6);

        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 2; k++) begin
                int r;
                r = int'($urandom % 16);
                req[k] = ($urandom % 4) != 0;
                stall[k] = ($urandom % 8) == 0;
                we[k] = $urandom % 2;
                if (r == 0) addr[k] = BASE + 32'(4 * MD) + 4 * ($urandom % 4);
                else if (r == 1) addr[k] = BASE - 4;
                else addr[k] = BASE + 4 * ($urandom % 8) + ($urandom % 4);
                wdata[k] = $urandom;
                be[k] = 4'($urandom);
                wintg[k] = enc(wdata[k]);
                if (($urandom % 8) == 0) wintg[k] ^= 7'(1 << ($urandom % 7));
            end
            @(posedge clk); #1;
        end
        for (int k = 0; k < 2; k++) begin
            req[k] = 1'b0; stall[k] = 1'b0;
        end
        repeat (6) @(posedge clk);
        #1;

        stall[1] = 1'b1; req[1] = 1'b1; we[1] = 1'b0; addr[1] = BASE;
        repeat (4) begin
            @(negedge clk);
            chk("stall_gnt", gnt[1], 0);
            @(posedge clk); #1;
        end
        stall[1] = 1'b0;
        @(negedge clk);
        chk("unstall_gnt", gnt[1], 1);
        @(posedge clk); #1;
        req[1] = 1'b0;
        base_n = resp_n[1];
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_rvalid", rvalid[1], 0);
        chk("mid_rst_err", err[1], 0);
        chk("mid_rst_rdata", rdata[1], 0);
        chk("mid_rst_intg", rintg[1], 7'h2A);
        chk("mid_rst_cnt", 32'(dut_b.outstanding), 0);
        repeat (6) @(posedge clk);
        #1;
        chk("dropped_resp", resp_n[1] - base_n, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
